// File: rtl/ic_trace_capture.sv
// ic_trace_capture
//   Multi-channel trace capture. Each channel owns a 1-deep pending slot that
//   latches {value, timestamp} on a qualified request. A round-robin arbiter
//   moves one pending slot per cycle into a first-word-fall-through record
//   FIFO. Samples that arrive while their slot is still occupied are dropped
//   and counted.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   enable     permits capture and timestamp counting
//   clear      flushes slots, FIFO, arbiter pointer and drop status (ts kept)
//   ch_valid   per-channel capture request
//   ch_data    per-channel values, channel i at [i*DATA_W +: DATA_W]
//   out_valid  record available at FIFO head
//   out_ready  consumer accepts head record when out_valid && out_ready
//   out_ch     channel index of head record (0 when empty)
//   out_data   captured value of head record (0 when empty)
//   out_ts     timestamp of head record (0 when empty)
//   overflow   sticky, at least one capture dropped
//   drop_cnt   saturating count of dropped captures
//
// Build option
//   IC_TRACE_CHANGE_ONLY_EN: when defined, a channel captures only when its
//   value differs from the last value it captured (first capture after
//   reset/clear is always taken). Suppressed samples are not drops.

module ic_trace_capture #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [TS_W-1:0]   r_ts;
  logic [CH_W-1:0]   r_ptr;
  logic [NUM_CH-1:0] r_pend_vld;
  logic [DATA_W-1:0] r_pend_data [NUM_CH];
  logic [TS_W-1:0]   r_pend_ts   [NUM_CH];

  logic [CH_W-1:0]   r_fifo_ch   [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [TS_W-1:0]   r_fifo_ts   [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;

  logic              r_overflow;
  logic [15:0]       r_drop_cnt;

  logic              w_empty;
  logic              w_full;
  logic              w_rd;
  logic              w_grant_any;
  logic              w_grant_vld;
  logic [CH_W-1:0]   w_grant_idx;
  logic [CH_W-1:0]   w_ptr_next;
  logic [NUM_CH-1:0] w_grant_oh;
  logic [NUM_CH-1:0] w_new;
  logic [NUM_CH-1:0] w_cap;
  logic [NUM_CH-1:0] w_accept;
  logic [NUM_CH-1:0] w_drop;
  logic [4:0]        w_drop_n;
  logic [16:0]       w_drop_sum;

  // Channel index `off` positions after `base`, wrapping at NUM_CH.
  function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return CH_W'(s);
  endfunction

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = ((r_wr_ptr - r_rd_ptr) == (AW+1)'(DEPTH));
  assign w_rd    = !w_empty && out_ready;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (r_pend_vld[rr_idx(r_ptr, k)]) begin
        w_grant_any = 1'b1;
        w_grant_idx = rr_idx(r_ptr, k);
      end
    end
  end

  // A full FIFO blocks the grant even if the head is being read this cycle.
  assign w_grant_vld = w_grant_any && !w_full && !clear;
  assign w_ptr_next  = (w_grant_idx == CH_W'(NUM_CH-1)) ? '0 : w_grant_idx + 1'b1;

`ifdef IC_TRACE_CHANGE_ONLY_EN
  logic [NUM_CH-1:0] r_last_vld;
  logic [DATA_W-1:0] r_last_data [NUM_CH];

  always_comb begin
    w_new = '0;
    for (int i = 0; i < NUM_CH; i++)
      w_new[i] = !r_last_vld[i] || (ch_data[i*DATA_W +: DATA_W] != r_last_data[i]);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_last_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (w_accept[i]) r_last_vld[i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (w_accept[i]) r_last_data[i] <= ch_data[i*DATA_W +: DATA_W];
  end
`else
  assign w_new = '1;
`endif

  // A slot granted this cycle is free for a same-cycle request.
  always_comb begin
    w_grant_oh = '0;
    w_cap      = '0;
    w_accept   = '0;
    w_drop     = '0;
    w_drop_n   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_grant_oh[i] = w_grant_vld && (w_grant_idx == CH_W'(i));
      w_cap[i]      = enable && !clear && ch_valid[i] && w_new[i];
      w_accept[i]   = w_cap[i] && (!r_pend_vld[i] || w_grant_oh[i]);
      w_drop[i]     = w_cap[i] && r_pend_vld[i] && !w_grant_oh[i];
      w_drop_n      = w_drop_n + 5'(w_drop[i]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts       <= '0;
      r_ptr      <= '0;
      r_pend_vld <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (enable) r_ts <= r_ts + 1'b1;
      if (clear) begin
        r_ptr      <= '0;
        r_pend_vld <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else begin
        if (w_grant_vld) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_ptr    <= w_ptr_next;
        end
        if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_accept[i])        r_pend_vld[i] <= 1'b1;
          else if (w_grant_oh[i]) r_pend_vld[i] <= 1'b0;
        end
        if (|w_drop) begin
          r_overflow <= 1'b1;
          r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_accept[i]) begin
        r_pend_data[i] <= ch_data[i*DATA_W +: DATA_W];
        r_pend_ts[i]   <= r_ts;
      end
    end
    if (w_grant_vld) begin
      r_fifo_ch[r_wr_ptr[AW-1:0]]   <= w_grant_idx;
      r_fifo_data[r_wr_ptr[AW-1:0]] <= r_pend_data[w_grant_idx];
      r_fifo_ts[r_wr_ptr[AW-1:0]]   <= r_pend_ts[w_grant_idx];
    end
  end

  // Head fields are forced to zero while empty so reset values are defined
  // without resetting the storage array.
  assign out_valid = !w_empty;
  assign out_ch    = w_empty ? '0 : r_fifo_ch[r_rd_ptr[AW-1:0]];
  assign out_data  = w_empty ? '0 : r_fifo_data[r_rd_ptr[AW-1:0]];
  assign out_ts    = w_empty ? '0 : r_fifo_ts[r_rd_ptr[AW-1:0]];
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_ic_trace_capture.sv
module tb_ic_trace_capture;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         clear;
  logic [3:0]   ch_valid;
  logic [127:0] ch_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_ch;
  logic [31:0]  out_data;
  logic [31:0]  out_ts;
  logic         overflow;
  logic [15:0]  drop_cnt;

  ic_trace_capture dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .ch_valid(ch_valid), .ch_data(ch_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .out_ts(out_ts),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] tb_ts    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) tb_ts = 0;
    else if (enable) tb_ts = tb_ts + 1;
    #1;
  endtask

  task automatic push(input int ch, input logic [31:0] data, input logic [31:0] ts);
    exp_t e;
    e.ch = 2'(ch); e.data = data; e.ts = ts;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    exp_t e;
    int   n;
    n = 0;
    out_ready = 1'b1;
    while (sb_q.size() > 0 && n < budget) begin
      if (out_valid) begin
        e = sb_q.pop_front();
        check("rec_ch",   64'(out_ch),   64'(e.ch));
        check("rec_data", 64'(out_data), 64'(e.data));
        check("rec_ts",   64'(out_ts),   64'(e.ts));
      end
      tick();
      n++;
    end
    if (sb_q.size() > 0) begin
      check("drain_timeout_left", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
    for (int k = 0; k < 3; k++) begin
      check("drain_extra", 64'(out_valid), 64'd0);
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [31:0] ts_k0;

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; ch_valid = '0; ch_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid",    64'(out_valid), 64'd0);
    check("rst_ch",       64'(out_ch),    64'd0);
    check("rst_data",     64'(out_data),  64'd0);
    check("rst_ts",       64'(out_ts),    64'd0);
    check("rst_overflow", 64'(overflow),  64'd0);
    check("rst_dropcnt",  64'(drop_cnt),  64'd0);

    // single capture on channel 2 at ts=5, two-edge latency
    enable = 1'b1;
    repeat (5) tick();
    ch_valid = 4'b0100;
    ch_data[2*32 +: 32] = 32'hCAFE;
    push(2, 32'hCAFE, 32'd5);
    tick();
    ch_valid = '0;
    check("lat_edge1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_edge2_valid", 64'(out_valid), 64'd1);
    drain(10);

    // all four channels in one cycle: round-robin order 0..3, equal ts
    pulse_clear();
    ch_valid = 4'b1111;
    for (int i = 0; i < 4; i++) ch_data[i*32 +: 32] = 32'h100 + i;
    for (int i = 0; i < 4; i++) push(i, 32'h100 + i, tb_ts);
    tick();
    ch_valid = '0;
    drain(20);

    // back-pressure: ch0 every cycle for 20 cycles into a 16-deep FIFO
    out_ready = 1'b0;
    ts_k0 = tb_ts;
    for (int k = 0; k < 20; k++) begin
      ch_valid = 4'b0001;
      ch_data[31:0] = 32'h1000 + k;
      if (k <= 16) push(0, 32'h1000 + k, tb_ts);
      tick();
    end
    ch_valid = '0;
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_dropcnt",  64'(drop_cnt), 64'd3);
    check("bp_head",     64'(out_data), 64'h1000);
    tick(); tick();
    check("bp_hold_data", 64'(out_data), 64'h1000);
    check("bp_hold_ts",   64'(out_ts),   64'(ts_k0));
    drain(60);
    check("bp_overflow_sticky", 64'(overflow), 64'd1);

    // repeated values on ch1
    for (int k = 0; k < 4; k++) begin
      ch_valid = 4'b0010;
      ch_data[1*32 +: 32] = (k == 3) ? 32'd9 : 32'd7;
`ifdef IC_TRACE_CHANGE_ONLY_EN
      if (k == 0 || k == 3) push(1, ch_data[1*32 +: 32], tb_ts);
`else
      push(1, ch_data[1*32 +: 32], tb_ts);
`endif
      tick();
    end
    ch_valid = '0;
    drain(20);
    check("rep_dropcnt", 64'(drop_cnt), 64'd3);

    // drop counter: exact count, saturation, then clear
    pulse_clear();
    check("clr_dropcnt0", 64'(drop_cnt), 64'd0);
    ch_valid = 4'b1111;
    for (int c = 0; c < 16420; c++) begin
      for (int i = 0; i < 4; i++) ch_data[i*32 +: 32] = 32'(c * 4 + i);
      tick();
      if (c == 99) check("drop_exact_100", 64'(drop_cnt), 64'd380);
      if (c == 16399) check("drop_sat", 64'(drop_cnt), 64'hFFFF);
    end
    check("drop_sat_hold", 64'(drop_cnt), 64'hFFFF);
    check("drop_overflow", 64'(overflow), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ch_valid = '0;
    check("clr_dropcnt",  64'(drop_cnt),  64'd0);
    check("clr_overflow", 64'(overflow),  64'd0);
    check("clr_valid",    64'(out_valid), 64'd0);
    tick(); tick();
    check("clr_ignored_valid", 64'(out_valid), 64'd0);

    // reset with five records queued
    for (int k = 0; k < 5; k++) begin
      ch_valid = 4'b0001;
      ch_data[31:0] = 32'h2000 + k;
      push(0, 32'h2000 + k, tb_ts);
      tick();
    end
    ch_valid = '0;
    tick();
    check("q5_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    sb_q.delete();
    check("rst2_valid",    64'(out_valid), 64'd0);
    check("rst2_ch",       64'(out_ch),    64'd0);
    check("rst2_data",     64'(out_data),  64'd0);
    check("rst2_ts",       64'(out_ts),    64'd0);
    check("rst2_overflow", 64'(overflow),  64'd0);
    check("rst2_dropcnt",  64'(drop_cnt),  64'd0);
    rst = 1'b0;

    // enable low: no capture, ts held
    enable = 1'b0;
    ch_valid = 4'b1111;
    tick(); tick();
    ch_valid = '0;
    tick(); tick();
    check("dis_valid", 64'(out_valid), 64'd0);
    enable = 1'b1;
    repeat (3) tick();
    ch_valid = 4'b1000;
    ch_data[3*32 +: 32] = 32'hBEEF;
    push(3, 32'hBEEF, 32'd3);
    tick();
    ch_valid = '0;
    drain(10);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
